// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate-library truth checkers.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int IDX_AND       = 0;
  localparam int IDX_OR        = 1;
  localparam int IDX_XOR       = 2;
  localparam int IDX_NOT       = 3;
  localparam int N_OUT_DEFAULT = 4;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden reference for the basic gate library, packed in
// the order {NOT(in[0]), XOR, OR, AND}.
module gate_ref_model
  import gate_check_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = N_OUT_DEFAULT
) (
  input  logic [N_IN-1:0]  vec,
  output logic [N_OUT-1:0] expected
);

  // reference gate outputs; any bits beyond the four gates read as zero
  always_comb begin
    expected          = '0;
    expected[IDX_AND] = &vec;
    expected[IDX_OR]  = |vec;
    expected[IDX_XOR] = ^vec;
    expected[IDX_NOT] = ~vec[0];
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps every gate input vector, waits a settle window, samples the gate
// outputs and accumulates mismatches against gate_ref_model.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = N_OUT_DEFAULT,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   err_vec,
  output logic [N_OUT-1:0]  err_mask
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [N_IN:0]      err_count_q, err_count_d;
  logic [N_IN-1:0]    err_vec_q, err_vec_d;
  logic [N_OUT-1:0]   err_mask_q, err_mask_d;
  logic               first_err_q, first_err_d;
  logic [N_OUT-1:0]   ref_s;
  logic [N_OUT-1:0]   diff_s;

  gate_ref_model #(.N_IN(N_IN), .N_OUT(N_OUT)) u_ref (
    .vec      (vec_q),
    .expected (ref_s)
  );

  assign diff_s = dut_out ^ ref_s;

  // next-state, counters and error accumulation
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    err_vec_d    = err_vec_q;
    err_mask_d   = err_mask_q;
    first_err_d  = first_err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          settle_cnt_d = '0;
          vec_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          err_count_d  = '0;
          err_vec_d    = '0;
          err_mask_d   = '0;
          first_err_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        settle_cnt_d = settle_cnt_q + CNT_W'(1);
        if (settle_cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_SAMPLE: begin
        if (|diff_s) begin
          err_count_d = err_count_q + (N_IN+1)'(1);
          if (!first_err_q) begin
            err_vec_d   = vec_q;
            err_mask_d  = diff_s;
            first_err_d = 1'b1;
          end else begin
            first_err_d = first_err_q;
          end
        end else begin
          err_count_d = err_count_q;
        end
        if (vec_q == {N_IN{1'b1}}) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end else begin
          state_d      = ST_DRIVE;
          vec_d        = vec_q + N_IN'(1);
          settle_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      err_vec_q    <= '0;
      err_mask_q   <= '0;
      first_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      err_vec_q    <= err_vec_d;
      err_mask_q   <= err_mask_d;
      first_err_q  <= first_err_d;
    end
  end

  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_vec   = err_vec_q;
  assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a default instance and an N_IN=3/SETTLE=1
// instance, both checked every cycle against a sweep-time model.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  int   fault_a, fault_b;

  logic [1:0] vec_a;   logic [3:0] dout_a;
  logic busy_a, done_a, pass_a;
  logic [2:0] ecnt_a;  logic [1:0] evec_a;  logic [3:0] emask_a;

  logic [2:0] vec_b;   logic [3:0] dout_b;
  logic busy_b, done_b, pass_b;
  logic [3:0] ecnt_b;  logic [2:0] evec_b;  logic [3:0] emask_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gate_truth_checker dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_out(dout_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(ecnt_a),
    .err_vec(evec_a), .err_mask(emask_a)
  );

  gate_truth_checker #(.N_IN(3), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .dut_out(dout_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(ecnt_b),
    .err_vec(evec_b), .err_mask(emask_b)
  );

  // Gate behaviour from truth-table rules; flt 1 = AND stuck 0, flt 2 = XOR inverted
  function automatic logic [3:0] gate_fn(input int nin, input int v, input int flt);
    logic a, o, x, n;
    a = (v == (1 << nin) - 1);
    o = (v != 0);
    x = ($countones(v) % 2 == 1);
    n = (v % 2 == 0);
    if (flt == 1) a = 1'b0;
    if (flt == 2) x = !x;
    return {n, x, o, a};
  endfunction

  always_comb dout_a = gate_fn(2, int'(vec_a), fault_a);
  always_comb dout_b = gate_fn(3, int'(vec_b), fault_b);

  typedef struct {
    int vec; int busy; int done; int pass; int cnt; int evec; int emask;
  } exp_t;

  // Expected outputs t edges after the start edge of a sweep
  function automatic exp_t model(input int nin, input int s, input int flt,
                                 input int t, input bit act);
    exp_t e;
    int nv, comp;
    logic [3:0] m;
    e = '{0, 0, 0, 0, 0, 0, 0};
    nv = 1 << nin;
    if (act) begin
      if (t < nv * (s + 1)) begin
        e.busy = 1; e.vec = t / (s + 1);
      end else begin
        e.done = 1; e.vec = nv - 1;
      end
      comp = t / (s + 1);
      if (comp > nv) comp = nv;
      for (int k = 0; k < comp; k++) begin
        m = gate_fn(nin, k, flt) ^ gate_fn(nin, k, 0);
        if (m != 4'd0) begin
          if (e.cnt == 0) begin
            e.evec = k; e.emask = int'(m);
          end
          e.cnt++;
        end
      end
      e.pass = (e.done == 1 && e.cnt == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  localparam int LA = 4 * 5;
  localparam int LB = 8 * 2;
  bit act_a, act_b;
  int t_a, t_b, flt_a_run, flt_b_run;

  // Sweep-time tracking for the model; start honoured only when idle or done
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_a <= 1'b0; t_a <= 0; act_b <= 1'b0; t_b <= 0;
    end else begin
      if (start_a && (!act_a || t_a >= LA)) begin
        act_a <= 1'b1; t_a <= 0; flt_a_run <= fault_a;
      end else if (act_a && t_a < LA) t_a <= t_a + 1;
      if (start_b && (!act_b || t_b >= LB)) begin
        act_b <= 1'b1; t_b <= 0; flt_b_run <= fault_b;
      end else if (act_b && t_b < LB) t_b <= t_b + 1;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    exp_t ea, eb;
    ea = model(2, 4, flt_a_run, t_a, act_a);
    eb = model(3, 1, flt_b_run, t_b, act_b);
    chk("a_vec", int'(vec_a), ea.vec);
    chk("a_busy", int'(busy_a), ea.busy);
    chk("a_done", int'(done_a), ea.done);
    chk("a_pass", int'(pass_a), ea.pass);
    chk("a_err_count", int'(ecnt_a), ea.cnt);
    chk("a_err_vec", int'(evec_a), ea.evec);
    chk("a_err_mask", int'(emask_a), ea.emask);
    chk("b_vec", int'(vec_b), eb.vec);
    chk("b_busy", int'(busy_b), eb.busy);
    chk("b_done", int'(done_b), eb.done);
    chk("b_pass", int'(pass_b), eb.pass);
    chk("b_err_count", int'(ecnt_b), eb.cnt);
    chk("b_err_vec", int'(evec_b), eb.evec);
    chk("b_err_mask", int'(emask_b), eb.emask);
  end

  // Pulse start, then count edges after the start edge until done (bounded)
  task automatic sweep(input bit use_b, input int p1, input int p2, output int n);
    @(posedge clk); #2;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0; start_b = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk); n++; #2;
      if (use_b) start_b = (n == p1 || n == p2);
      else start_a = (n == p1 || n == p2);
      if ((use_b ? done_b : done_a) == 1'b1) break;
    end
    start_a = 1'b0; start_b = 1'b0;
    if (n >= 200) chk("sweep_timeout", n, -1);
  endtask

  int n;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; fault_a = 0; fault_b = 0;
    flt_a_run = 0; flt_b_run = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_vec", int'(vec_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_err_count", int'(ecnt_a), 0);

    // 1: correct gates
    sweep(1'b0, -1, -1, n);
    chk("t1_done_edge", n, 20);
    chk("t1_pass", int'(pass_a), 1);
    chk("t1_err_count", int'(ecnt_a), 0);
    chk("t1_err_mask", int'(emask_a), 0);

    // 2: AND stuck at 0
    fault_a = 1;
    sweep(1'b0, -1, -1, n);
    chk("t2_err_count", int'(ecnt_a), 1);
    chk("t2_err_vec", int'(evec_a), 3);
    chk("t2_err_mask", int'(emask_a), 1);
    chk("t2_pass", int'(pass_a), 0);

    // 3: XOR inverted
    fault_a = 2;
    sweep(1'b0, -1, -1, n);
    chk("t3_err_count", int'(ecnt_a), 4);
    chk("t3_err_vec", int'(evec_a), 0);
    chk("t3_err_mask", int'(emask_a), 4);

    // 4: reset during DRIVE of vector 01
    fault_a = 0;
    @(posedge clk); #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_vec", int'(vec_a), 0);
    chk("t4_rst_busy", int'(busy_a), 0);
    chk("t4_rst_done", int'(done_a), 0);
    @(posedge clk); #2 rst = 1'b0;
    sweep(1'b0, -1, -1, n);
    chk("t4_done_edge", n, 20);
    chk("t4_pass", int'(pass_a), 1);

    // 5: start mid-sweep and during last SAMPLE ignored; start in DONE re-sweeps
    fault_a = 1;
    sweep(1'b0, 7, 19, n);
    chk("t5_done_edge", n, 20);
    chk("t5_err_count", int'(ecnt_a), 1);
    @(posedge clk); #2;
    chk("t5_done_sticky", int'(done_a), 1);
    fault_a = 0;
    sweep(1'b0, -1, -1, n);
    chk("t5_resweep_edge", n, 20);
    chk("t5_resweep_pass", int'(pass_a), 1);

    // 6: N_IN=3, SETTLE=1
    sweep(1'b1, -1, -1, n);
    chk("t6_done_edge", n, 16);
    chk("t6_pass", int'(pass_b), 1);
    fault_b = 2;
    sweep(1'b1, -1, -1, n);
    chk("t6_err_count", int'(ecnt_b), 8);
    chk("t6_err_mask", int'(emask_b), 4);

    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
